// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: one time-shared signed MAC,
// ROM-fed inputs/weights/bias, saturate, optional ReLU, arg-max.
module fc_layer_engine #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 10,
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter bit RELU_EN = 1'b1,
  localparam int IA_W   = $clog2(N_IN),
  localparam int OA_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int ACC_W  = 2*DATA_W + IA_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IA_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]    in_data,
  output logic [IA_W+OA_W-1:0] w_addr,
  input  logic [DATA_W-1:0]    w_data,
  output logic [OA_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 out_valid,
  output logic [OA_W-1:0]      out_idx,
  output logic [DATA_W-1:0]    out_data,
  output logic [31:0]          guess
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    r_state;
  logic [IA_W-1:0]           r_i;
  logic [OA_W-1:0]           r_j;
  logic                      r_mac_vld;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_out_valid;
  logic [OA_W-1:0]           r_out_idx;
  logic signed [DATA_W-1:0]  r_out_data;
  logic [OA_W-1:0]           r_best_idx;
  logic signed [DATA_W-1:0]  r_best_val;
  logic [OA_W-1:0]           r_guess;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_x;
  logic signed [ACC_W-1:0]    w_bias_x;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [DATA_W-1:0]   w_sat;
  logic signed [DATA_W-1:0]   w_res;
  logic                       w_last_i;
  logic                       w_last_j;

  assign w_prod   = $signed(in_data) * $signed(w_data);
  assign w_prod_x = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_bias_x = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
  assign w_sum    = r_acc + (w_bias_x <<< FRAC_W);
  assign w_shr    = w_sum >>> FRAC_W;
  assign w_last_i = (r_i == IA_W'(N_IN-1));
  assign w_last_j = (r_j == OA_W'(N_OUT-1));

  // Clamp the rescaled sum to the output range, then optional ReLU.
  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > SAT_HI)
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < SAT_LO)
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    w_res = w_sat;
    if (RELU_EN && w_sat[DATA_W-1])
      w_res = '0;
  end

  // Layer sequencer with MAC accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_mac_vld   <= 1'b0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_guess     <= '0;
    end else begin
      r_busy      <= (r_state != S_IDLE);
      r_mac_vld   <= (r_state == S_RUN);
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      if (r_mac_vld)
        r_acc <= r_acc + w_prod_x;
      unique case (r_state)
        S_IDLE: begin
          r_i <= '0;
          r_j <= '0;
          if (start) begin
            r_acc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_i)
            r_state <= S_DRAIN;
          else
            r_i <= r_i + IA_W'(1);
        end
        S_DRAIN: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_out_valid <= 1'b1;
          r_out_idx   <= r_j;
          r_out_data  <= w_res;
          if (r_j == '0 || w_res > r_best_val) begin
            r_best_val <= w_res;
            r_best_idx <= r_j;
          end
          r_acc <= '0;
          r_i   <= '0;
          if (w_last_j) begin
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + OA_W'(1);
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_guess <= r_best_idx;
          r_i     <= '0;
          r_j     <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_addr   = r_i;
  assign w_addr    = {r_j, r_i};
  assign b_addr    = r_j;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign guess     = 32'(r_guess);

endmodule
